fft_peak_detector: RTL and testbench
====================================

Name: fft_peak_detector

Overview:
- Downstream consumer of the FFT megafunction output stream: per-sample 25-bit signed real/imag bins framed by source_sop/source_eop.
- Computes bin power re^2+im^2 and forwards it as a pipelined power stream.
- Searches the positive-frequency half of each frame for the maximum-power bin and reports bin index and power once per frame.
- Flags framing errors.

Parameters:
- DATA_W, 25, width of signed real/imag input samples
- PTS_W, 11, width of fft_pts / bin index (max frame 1024)
- POW_W, 50, power width; must equal 2*DATA_W
- SKIP_DC, 1, when 1 bin 0 is excluded from peak search

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input sample valid (FFT source_valid)
- in_sop  in  1  first bin of frame, qualified by in_valid
- in_eop  in  1  last bin of frame, qualified by in_valid
- in_real  in  DATA_W  signed real part
- in_imag  in  DATA_W  signed imag part
- fft_pts  in  PTS_W  frame length N, sampled on the sop cycle
- pow_valid  out  1  power stream valid
- pow_sop  out  1  power stream sop
- pow_eop  out  1  power stream eop
- pow_out  out  POW_W  unsigned re^2+im^2
- peak_valid  out  1  one-cycle pulse: peak result valid
- peak_bin  out  PTS_W  index of maximum-power bin
- peak_pow  out  POW_W  power of that bin
- frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset: all outputs 0; FSM to IDLE; bin counter, running max and index cleared. Reset mid-frame aborts the frame with no peak_valid and no frame_err.
- Power pipeline, 3 stages, independent of FSM:
  - S1 registers inputs.
  - S2 forms two signed squares (2*DATA_W bits each).
  - S3 forms the unsigned sum, truncated to POW_W. This is lossless: max (-2^24)^2 * 2 = 2^49 < 2^50.
  - pow_valid/sop/eop are in_valid/sop/eop delayed 3 cycles; pow_out is updated only when valid.
  - Every valid input sample appears on the power stream, including out-of-frame samples.
- FSM states IDLE, ACCUM, REPORT, driven by S3 outputs:
  - IDLE: on pow_valid & pow_sop: latch N. If N < 4, pulse frame_err and stay in IDLE. Otherwise set bin=0, load max with this sample (or 0 if SKIP_DC) and idx=0, go to ACCUM. pow_valid without sop is ignored.
  - ACCUM: each pow_valid increments bin.
    - Bins 1..N/2-1 take part in the search. Update rule: power strictly greater than max → max=power, idx=bin. Ties keep the lowest index.
    - Bins N/2..N-1 are counted but not searched.
    - pow_sop while in ACCUM: pulse frame_err, discard the partial frame, restart as in IDLE with this sample as bin 0 (same cycle, no gap).
    - pow_eop with bin == N-1: go to REPORT.
    - pow_eop with bin != N-1, or bin reaching N-1 without eop: pulse frame_err, go to IDLE. If a late eop follows, it is handled as an ignored IDLE sample.
    - Simultaneous sop & eop in one sample: treated as a sop restart, followed by an eop error (N >= 4).
  - REPORT: one cycle. peak_valid=1, peak_bin=idx, peak_pow=max. Then go to IDLE.
    - A sop arriving in the REPORT cycle is accepted: the FSM transitions directly to ACCUM after reporting.
- peak_bin/peak_pow hold their values until the next report.
- Latency: input eop cycle t gives pow_eop at t+3 and peak_valid at t+4.
- No backpressure: the block always accepts; upstream source_ready is tied high.
- SKIP_DC=1 with all bins 1..N/2-1 at zero power: peak_bin=0, peak_pow=0.

Test Plan:
- N=16; bin 5 real=1000, imag=-2000; all other bins 0 → pow_out at bin 5 = 5,000,000; peak_valid 4 cycles after eop; peak_bin=5, peak_pow=5,000,000.
- N=8; bins 2 and 3 both real=300, others 0 → peak_bin=2 (tie keeps lowest); bin 6 real=10000 is ignored (upper half).
- Full-scale: real=imag=-16,777,216 at bin 1, N=1024 → pow_out=562,949,953,421,312 (2^49); peak_pow=2^49, peak_bin=1.
- N=16, eop on bin 9 → frame_err pulse at t+4, no peak_valid. A following clean frame reports correctly.
- N=16, new sop at bin 7 of a frame → frame_err pulse; the second frame, peak at bin 3, reports peak_bin=3.
- Assert reset for 1 cycle mid-ACCUM → all outputs 0. Following eop produces no peak_valid and no frame_err. Gaps in in_valid inside a frame do not affect the result.

Source files
------------

// File: rtl/fft_peak_detector_if.sv
// Stream bundle between the FFT source, the peak detector and its power/peak consumers.
// in_* follows FFT source_valid semantics with no ready: a beat is consumed on every edge where in_valid is high.
interface fft_peak_detector_if #(
    parameter int DATA_W = 25,
    parameter int PTS_W  = 11,
    parameter int POW_W  = 50
) ();
    logic                     in_valid;
    logic                     in_sop;
    logic                     in_eop;
    logic signed [DATA_W-1:0] in_real;
    logic signed [DATA_W-1:0] in_imag;
    logic [PTS_W-1:0]         fft_pts;

    logic                     pow_valid;
    logic                     pow_sop;
    logic                     pow_eop;
    logic [POW_W-1:0]         pow_out;

    logic                     peak_valid;
    logic [PTS_W-1:0]         peak_bin;
    logic [POW_W-1:0]         peak_pow;
    logic                     frame_err;

    modport master (
        output in_valid, in_sop, in_eop, in_real, in_imag, fft_pts,
        input  pow_valid, pow_sop, pow_eop, pow_out,
        input  peak_valid, peak_bin, peak_pow, frame_err
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_real, in_imag, fft_pts,
        output pow_valid, pow_sop, pow_eop, pow_out,
        output peak_valid, peak_bin, peak_pow, frame_err
    );
endinterface

// File: rtl/fft_peak_detector.sv
// Bin power stream (re^2+im^2, 3-cycle pipeline) plus per-frame search of the
// positive-frequency half for the strongest bin, with framing error detection.
module fft_peak_detector #(
    parameter int DATA_W  = 25,
    parameter int PTS_W   = 11,
    parameter int POW_W   = 50,
    parameter bit SKIP_DC = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    fft_peak_detector_if.slave bus,
    output logic [1:0]         dbg_state
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    localparam logic [PTS_W-1:0] MIN_PTS = PTS_W'(4);

    logic                       s1_valid;
    logic                       s1_sop;
    logic                       s1_eop;
    logic signed [DATA_W-1:0]   s1_re;
    logic signed [DATA_W-1:0]   s1_im;
    logic [PTS_W-1:0]           s1_pts;

    logic                       s2_valid;
    logic                       s2_sop;
    logic                       s2_eop;
    logic signed [2*DATA_W-1:0] s2_sq_re;
    logic signed [2*DATA_W-1:0] s2_sq_im;
    logic [PTS_W-1:0]           s2_pts;

    // Frame length travels with the sample so the FSM sees it aligned to pow_sop.
    logic [PTS_W-1:0]           s3_pts;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_sop        <= 1'b0;
            s1_eop        <= 1'b0;
            s1_re         <= '0;
            s1_im         <= '0;
            s1_pts        <= '0;
            s2_valid      <= 1'b0;
            s2_sop        <= 1'b0;
            s2_eop        <= 1'b0;
            s2_sq_re      <= '0;
            s2_sq_im      <= '0;
            s2_pts        <= '0;
            s3_pts        <= '0;
            bus.pow_valid <= 1'b0;
            bus.pow_sop   <= 1'b0;
            bus.pow_eop   <= 1'b0;
            bus.pow_out   <= '0;
        end else begin
            s1_valid      <= bus.in_valid;
            s1_sop        <= bus.in_valid & bus.in_sop;
            s1_eop        <= bus.in_valid & bus.in_eop;
            s1_re         <= bus.in_real;
            s1_im         <= bus.in_imag;
            s1_pts        <= bus.fft_pts;

            s2_valid      <= s1_valid;
            s2_sop        <= s1_sop;
            s2_eop        <= s1_eop;
            s2_sq_re      <= (2*DATA_W)'(s1_re) * (2*DATA_W)'(s1_re);
            s2_sq_im      <= (2*DATA_W)'(s1_im) * (2*DATA_W)'(s1_im);
            s2_pts        <= s1_pts;

            bus.pow_valid <= s2_valid;
            bus.pow_sop   <= s2_sop;
            bus.pow_eop   <= s2_eop;
            if (s2_valid) begin
                bus.pow_out <= $unsigned(s2_sq_re) + $unsigned(s2_sq_im);
                s3_pts      <= s2_pts;
            end
        end
    end

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PTS_W-1:0] bin;
    logic [PTS_W-1:0] bin_nxt;
    logic [PTS_W-1:0] bin_inc;
    logic [PTS_W-1:0] n_pts;
    logic [PTS_W-1:0] n_nxt;
    logic [PTS_W-1:0] half_pts;
    logic [PTS_W-1:0] last_bin;
    logic [POW_W-1:0] max_pow;
    logic [POW_W-1:0] max_nxt;
    logic [PTS_W-1:0] max_idx;
    logic [PTS_W-1:0] idx_nxt;
    logic             err_nxt;
    logic             report_nxt;

    assign bin_inc   = bin + 1'b1;
    assign half_pts  = n_pts >> 1;
    assign last_bin  = n_pts - 1'b1;
    assign dbg_state = state;

    always_comb begin
        state_nxt  = state;
        bin_nxt    = bin;
        n_nxt      = n_pts;
        max_nxt    = max_pow;
        idx_nxt    = max_idx;
        err_nxt    = 1'b0;
        report_nxt = 1'b0;

        if (bus.pow_valid) begin
            if (bus.pow_sop) begin
                // A sop mid-frame drops the partial frame and restarts on this sample.
                n_nxt = s3_pts;
                if (state == ST_ACCUM) begin
                    err_nxt = 1'b1;
                end
                if (s3_pts < MIN_PTS) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    bin_nxt = '0;
                    max_nxt = SKIP_DC ? '0 : bus.pow_out;
                    idx_nxt = '0;
                    if (bus.pow_eop) begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_ACCUM;
                    end
                end
            end else if (state == ST_ACCUM) begin
                bin_nxt = bin_inc;
                // Strictly-greater keeps the lowest index on ties.
                if ((bin_inc < half_pts) && (bus.pow_out > max_pow)) begin
                    max_nxt = bus.pow_out;
                    idx_nxt = bin_inc;
                end
                if (bus.pow_eop) begin
                    if (bin_inc == last_bin) begin
                        report_nxt = 1'b1;
                        state_nxt  = ST_REPORT;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else if (bin_inc == last_bin) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end else begin
                state_nxt = ST_IDLE;
            end
        end else if (state == ST_REPORT) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            bin            <= '0;
            n_pts          <= '0;
            max_pow        <= '0;
            max_idx        <= '0;
            bus.peak_valid <= 1'b0;
            bus.peak_bin   <= '0;
            bus.peak_pow   <= '0;
            bus.frame_err  <= 1'b0;
        end else begin
            state          <= state_nxt;
            bin            <= bin_nxt;
            n_pts          <= n_nxt;
            max_pow        <= max_nxt;
            max_idx        <= idx_nxt;
            bus.peak_valid <= report_nxt;
            bus.frame_err  <= err_nxt;
            if (report_nxt) begin
                bus.peak_bin <= idx_nxt;
                bus.peak_pow <= max_nxt;
            end
        end
    end
endmodule

// File: tb/tb_fft_peak_detector.sv
// Directed bench for fft_peak_detector: power stream, peak search, framing errors and reset abort.
module tb_fft_peak_detector;
  localparam int DATA_W = 25;
  localparam int PTS_W  = 11;
  localparam int POW_W  = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  fft_peak_detector_if #(.DATA_W(DATA_W), .PTS_W(PTS_W), .POW_W(POW_W)) bus ();

  fft_peak_detector #(
    .DATA_W(DATA_W), .PTS_W(PTS_W), .POW_W(POW_W), .SKIP_DC(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_t   = 0;
  int first_t  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DATA_W-1:0] re_arr[1024];
  logic signed [DATA_W-1:0] im_arr[1024];

  // scoreboard: observed streams and expected queue
  logic [POW_W-1:0] exp_q[$];
  logic [POW_W-1:0] got_q[$];
  logic [PTS_W-1:0] pk_bin_q[$];
  logic [POW_W-1:0] pk_pow_q[$];
  int               pk_cyc_q[$];
  int               fe_cyc_q[$];
  int               peop_cyc_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pow_valid) begin
        got_q.push_back(bus.pow_out);
        if (bus.pow_eop) peop_cyc_q.push_back(cyc);
      end
      if (bus.peak_valid) begin
        pk_bin_q.push_back(bus.peak_bin);
        pk_pow_q.push_back(bus.peak_pow);
        pk_cyc_q.push_back(cyc);
      end
      if (bus.frame_err) fe_cyc_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic s, input logic e,
                       input logic signed [DATA_W-1:0] re, input logic signed [DATA_W-1:0] im,
                       input int n);
    bus.in_valid = v;
    bus.in_sop   = s;
    bus.in_eop   = e;
    bus.in_real  = re;
    bus.in_imag  = im;
    bus.fft_pts  = PTS_W'(n);
    if (v && e) last_t = cyc;
    if (v && s) first_t = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 0);
  endtask

  task automatic send_bins(input int n, input int first, input int count,
                           input bit do_sop, input bit do_eop);
    for (int i = first; i < first + count; i++)
      drive(1'b1, do_sop && (i == first), do_eop && (i == first + count - 1),
            re_arr[i], im_arr[i], n);
  endtask

  task automatic clear_arrays();
    for (int i = 0; i < 1024; i++) begin
      re_arr[i] = '0;
      im_arr[i] = '0;
    end
  endtask

  task automatic clear_obs();
    exp_q.delete();
    got_q.delete();
    pk_bin_q.delete();
    pk_pow_q.delete();
    pk_cyc_q.delete();
    fe_cyc_q.delete();
    peop_cyc_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    checks++;
    if (bus.pow_valid !== 1'b0 || bus.pow_sop !== 1'b0 || bus.pow_eop !== 1'b0) begin
      failures++;
      $display("FAIL reset_pow_flags: got %b%b%b required 000", bus.pow_valid, bus.pow_sop, bus.pow_eop);
    end
    checks++;
    if (bus.pow_out !== '0) begin failures++; $display("FAIL reset_pow_out: got %0d required 0", bus.pow_out); end
    checks++;
    if (bus.peak_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses: got pv=%b fe=%b required 0 0", bus.peak_valid, bus.frame_err);
    end
    checks++;
    if (bus.peak_bin !== '0 || bus.peak_pow !== '0) begin
      failures++;
      $display("FAIL reset_peak: got bin=%0d pow=%0d required 0 0", bus.peak_bin, bus.peak_pow);
    end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
  endtask

  task automatic test_single_peak();
    int eop_t;
    clear_arrays();
    clear_obs();
    re_arr[5] = 25'sd1000;
    im_arr[5] = -25'sd2000;
    send_bins(16, 0, 16, 1'b1, 1'b1);
    eop_t = last_t;
    idle(8);
    for (int i = 0; i < 16; i++) exp_q.push_back(i == 5 ? 50'd5000000 : 50'd0);
    checks++;
    if (got_q.size() != 16) begin failures++; $display("FAIL single_pow_count: got %0d required 16", got_q.size()); end
    for (int i = 0; i < 16 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL single_pow_bin%0d: got %0d required %0d", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (peop_cyc_q.size() != 1 || peop_cyc_q[0] != eop_t + 3) begin
      failures++;
      $display("FAIL single_pow_eop_latency: got %0d eops (first at %0d) required 1 at %0d",
               peop_cyc_q.size(), (peop_cyc_q.size() > 0) ? peop_cyc_q[0] : -1, eop_t + 3);
    end
    checks++;
    if (pk_cyc_q.size() != 1 || pk_cyc_q[0] != eop_t + 4) begin
      failures++;
      $display("FAIL single_peak_latency: got %0d peaks (first at %0d) required 1 at %0d",
               pk_cyc_q.size(), (pk_cyc_q.size() > 0) ? pk_cyc_q[0] : -1, eop_t + 4);
    end else begin
      checks++;
      if (pk_bin_q[0] !== 11'd5 || pk_pow_q[0] !== 50'd5000000) begin
        failures++;
        $display("FAIL single_peak_value: got bin=%0d pow=%0d required 5 5000000", pk_bin_q[0], pk_pow_q[0]);
      end
    end
    checks++;
    if (fe_cyc_q.size() != 0) begin failures++; $display("FAIL single_no_err: got %0d errors required 0", fe_cyc_q.size()); end
    checks++;
    if (bus.peak_bin !== 11'd5) begin failures++; $display("FAIL single_peak_hold: got %0d required 5", bus.peak_bin); end
  endtask

  task automatic test_tie_upper_half();
    clear_arrays();
    clear_obs();
    re_arr[2] = 25'sd300;
    re_arr[3] = 25'sd300;
    re_arr[6] = 25'sd10000;
    send_bins(8, 0, 8, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (got_q.size() != 8 || got_q[6] !== 50'd100000000) begin
      failures++;
      $display("FAIL tie_pow_bin6: got count=%0d value=%0d required 8 100000000",
               got_q.size(), (got_q.size() > 6) ? got_q[6] : 50'd0);
    end
    checks++;
    if (pk_bin_q.size() != 1 || pk_bin_q[0] !== 11'd2 || pk_pow_q[0] !== 50'd90000) begin
      failures++;
      $display("FAIL tie_peak: got %0d peaks bin=%0d pow=%0d required 1 2 90000", pk_bin_q.size(),
               (pk_bin_q.size() > 0) ? pk_bin_q[0] : 11'd0, (pk_pow_q.size() > 0) ? pk_pow_q[0] : 50'd0);
    end
  endtask

  task automatic test_full_scale();
    logic [POW_W-1:0] top;
    int bad;
    top = 50'd562949953421312;
    bad = 0;
    clear_arrays();
    clear_obs();
    re_arr[1] = 25'h1000000;
    im_arr[1] = 25'h1000000;
    send_bins(1024, 0, 1024, 1'b1, 1'b1);
    idle(8);
    for (int i = 0; i < 1024; i++) exp_q.push_back(i == 1 ? top : 50'd0);
    checks++;
    if (got_q.size() != 1024) begin failures++; $display("FAIL full_pow_count: got %0d required 1024", got_q.size()); end
    for (int i = 0; i < 1024 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        if (bad < 4) $display("FAIL full_pow_bin%0d: got %0d required %0d", i, got_q[i], exp_q[i]);
        bad++;
      end
    end
    checks++;
    if (pk_bin_q.size() != 1 || pk_bin_q[0] !== 11'd1 || pk_pow_q[0] !== top) begin
      failures++;
      $display("FAIL full_peak: got %0d peaks bin=%0d pow=%0d required 1 1 %0d", pk_bin_q.size(),
               (pk_bin_q.size() > 0) ? pk_bin_q[0] : 11'd0, (pk_pow_q.size() > 0) ? pk_pow_q[0] : 50'd0, top);
    end
  endtask

  task automatic test_early_eop();
    int eop_t;
    clear_arrays();
    clear_obs();
    re_arr[4] = 25'sd7;
    send_bins(16, 0, 10, 1'b1, 1'b1);
    eop_t = last_t;
    idle(8);
    checks++;
    if (fe_cyc_q.size() != 1 || fe_cyc_q[0] != eop_t + 4) begin
      failures++;
      $display("FAIL early_eop_err: got %0d errors (first at %0d) required 1 at %0d",
               fe_cyc_q.size(), (fe_cyc_q.size() > 0) ? fe_cyc_q[0] : -1, eop_t + 4);
    end
    checks++;
    if (pk_bin_q.size() != 0) begin failures++; $display("FAIL early_eop_no_peak: got %0d peaks required 0", pk_bin_q.size()); end
    send_bins(16, 0, 16, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (pk_bin_q.size() != 1 || pk_bin_q[0] !== 11'd4 || pk_pow_q[0] !== 50'd49) begin
      failures++;
      $display("FAIL early_eop_recover: got %0d peaks bin=%0d pow=%0d required 1 4 49", pk_bin_q.size(),
               (pk_bin_q.size() > 0) ? pk_bin_q[0] : 11'd0, (pk_pow_q.size() > 0) ? pk_pow_q[0] : 50'd0);
    end
    checks++;
    if (fe_cyc_q.size() != 1) begin failures++; $display("FAIL early_eop_clean_err: got %0d errors required 1", fe_cyc_q.size()); end
  endtask

  task automatic test_sop_restart();
    int sop_t;
    clear_arrays();
    clear_obs();
    re_arr[5] = 25'sd30000;
    send_bins(16, 0, 7, 1'b1, 1'b0);
    re_arr[5] = '0;
    re_arr[3] = 25'sd50;
    im_arr[3] = 25'sd50;
    send_bins(16, 0, 16, 1'b1, 1'b1);
    sop_t = first_t;
    idle(8);
    checks++;
    if (fe_cyc_q.size() != 1 || fe_cyc_q[0] != sop_t + 4) begin
      failures++;
      $display("FAIL restart_err: got %0d errors (first at %0d) required 1 at %0d",
               fe_cyc_q.size(), (fe_cyc_q.size() > 0) ? fe_cyc_q[0] : -1, sop_t + 4);
    end
    checks++;
    if (pk_bin_q.size() != 1 || pk_bin_q[0] !== 11'd3 || pk_pow_q[0] !== 50'd5000) begin
      failures++;
      $display("FAIL restart_peak: got %0d peaks bin=%0d pow=%0d required 1 3 5000", pk_bin_q.size(),
               (pk_bin_q.size() > 0) ? pk_bin_q[0] : 11'd0, (pk_pow_q.size() > 0) ? pk_pow_q[0] : 50'd0);
    end
  endtask

  task automatic test_small_n();
    clear_arrays();
    clear_obs();
    re_arr[1] = 25'sd9;
    send_bins(2, 0, 2, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (fe_cyc_q.size() != 1 || pk_bin_q.size() != 0) begin
      failures++;
      $display("FAIL small_n: got errors=%0d peaks=%0d required 1 0", fe_cyc_q.size(), pk_bin_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_arrays();
    clear_obs();
    re_arr[2] = 25'sd9;
    re_arr[5] = 25'sd11;
    send_bins(16, 0, 6, 1'b1, 1'b0);
    idle(4);
    checks++;
    if (dbg_state !== 2'd1 || bus.pow_out !== 50'd121) begin
      failures++;
      $display("FAIL mid_pre_reset: got state=%0d pow=%0d required 1 121", dbg_state, bus.pow_out);
    end
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    checks++;
    if (bus.pow_out !== '0 || bus.pow_valid !== 1'b0 || bus.peak_bin !== '0 || bus.peak_pow !== '0 ||
        bus.peak_valid !== 1'b0 || bus.frame_err !== 1'b0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got pow=%0d pv=%b bin=%0d ppow=%0d pk=%b fe=%b st=%0d required all 0",
               bus.pow_out, bus.pow_valid, bus.peak_bin, bus.peak_pow, bus.peak_valid, bus.frame_err, dbg_state);
    end
    send_bins(16, 6, 10, 1'b0, 1'b1);
    idle(8);
    checks++;
    if (pk_bin_q.size() != 0 || fe_cyc_q.size() != 0) begin
      failures++;
      $display("FAIL mid_tail_ignored: got peaks=%0d errors=%0d required 0 0", pk_bin_q.size(), fe_cyc_q.size());
    end
  endtask

  task automatic test_gaps_skip_dc();
    clear_arrays();
    clear_obs();
    re_arr[0] = 25'sd5000;
    re_arr[6] = 25'sd3;
    im_arr[6] = 25'sd4;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, i == 0, i == 15, re_arr[i], im_arr[i], 16);
      if (i % 3 == 1) idle(1);
    end
    idle(8);
    checks++;
    if (got_q.size() != 16 || got_q[0] !== 50'd25000000) begin
      failures++;
      $display("FAIL gaps_pow: got count=%0d bin0=%0d required 16 25000000",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 50'd0);
    end
    checks++;
    if (pk_bin_q.size() != 1 || pk_bin_q[0] !== 11'd6 || pk_pow_q[0] !== 50'd25) begin
      failures++;
      $display("FAIL gaps_peak: got %0d peaks bin=%0d pow=%0d required 1 6 25", pk_bin_q.size(),
               (pk_bin_q.size() > 0) ? pk_bin_q[0] : 11'd0, (pk_pow_q.size() > 0) ? pk_pow_q[0] : 50'd0);
    end
  endtask

  task automatic test_all_zero();
    clear_arrays();
    clear_obs();
    re_arr[0] = 25'sd77;
    re_arr[5] = 25'sd99;
    send_bins(8, 0, 8, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (pk_bin_q.size() != 1 || pk_bin_q[0] !== 11'd0 || pk_pow_q[0] !== 50'd0) begin
      failures++;
      $display("FAIL zero_peak: got %0d peaks bin=%0d pow=%0d required 1 0 0", pk_bin_q.size(),
               (pk_bin_q.size() > 0) ? pk_bin_q[0] : 11'd0, (pk_pow_q.size() > 0) ? pk_pow_q[0] : 50'd0);
    end
  endtask

  task automatic test_back_to_back();
    clear_arrays();
    clear_obs();
    re_arr[1] = 25'sd2;
    send_bins(8, 0, 8, 1'b1, 1'b1);
    re_arr[1] = '0;
    re_arr[3] = 25'sd3;
    send_bins(8, 0, 8, 1'b1, 1'b1);
    idle(8);
    checks++;
    if (pk_bin_q.size() != 2) begin
      failures++;
      $display("FAIL b2b_count: got %0d peaks required 2", pk_bin_q.size());
    end else begin
      checks++;
      if (pk_bin_q[0] !== 11'd1 || pk_pow_q[0] !== 50'd4) begin
        failures++;
        $display("FAIL b2b_first: got bin=%0d pow=%0d required 1 4", pk_bin_q[0], pk_pow_q[0]);
      end
      checks++;
      if (pk_bin_q[1] !== 11'd3 || pk_pow_q[1] !== 50'd9 || pk_cyc_q[1] - pk_cyc_q[0] != 8) begin
        failures++;
        $display("FAIL b2b_second: got bin=%0d pow=%0d spacing=%0d required 3 9 8",
                 pk_bin_q[1], pk_pow_q[1], pk_cyc_q[1] - pk_cyc_q[0]);
      end
    end
    checks++;
    if (fe_cyc_q.size() != 0) begin failures++; $display("FAIL b2b_no_err: got %0d errors required 0", fe_cyc_q.size()); end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_real  = '0;
    bus.in_imag  = '0;
    bus.fft_pts  = '0;
    test_reset();
    test_single_peak();
    test_tie_upper_half();
    test_full_scale();
    test_early_eop();
    test_sop_restart();
    test_small_n();
    test_reset_mid_frame();
    test_gaps_skip_dc();
    test_all_zero();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
